cmp_pipe_unit: RTL and testbench
================================

CMP_PIPE_UNIT -- requirements
Module: CMP_PIPE_UNIT

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the operand and data-result width.
REQ-002 Parameter CNT_WIDTH, default 8, SHALL set the width of the tracker sample counter.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 In_Valid  input  1  SHALL indicate that an operand pair and function are presented.
REQ-006 In_Ready  output  1  SHALL indicate that the block accepts input this cycle.
REQ-007 A, B  input  DATA_WIDTH each  SHALL be the operands.
REQ-008 Signed_Mode  input  1  SHALL select the compare type: 1 = two's-complement, 0 = unsigned.
REQ-009 CMP_FUN  input  3  SHALL select the function: 000 EQ, 001 NE, 010 GT, 011 LT, 100 GE, 101 LE, 110 MIN, 111 MAX.
REQ-010 Track_Clear  input  1  SHALL clear the running tracker.
REQ-011 Out_Valid  output  1  SHALL indicate that a result is held.
REQ-012 Out_Ready  input  1  SHALL indicate that the consumer takes the result.
REQ-013 CMP_OUT  output  1  SHALL carry the boolean result; it is 0 for MIN and MAX.
REQ-014 CMP_DATA  output  DATA_WIDTH  SHALL carry the selected operand for MIN and MAX, and 0 otherwise.
REQ-015 Track_MIN, Track_MAX  output  DATA_WIDTH each  SHALL carry the running extremes of accepted A values.
REQ-016 Track_CNT  output  CNT_WIDTH  SHALL carry the number of accepted samples since the last clear.

Function
REQ-017 Handshake: a transfer SHALL occur when In_Valid && In_Ready; In_Ready SHALL equal !Out_Valid || Out_Ready (combinational).
REQ-018 Latency: a result SHALL be registered on the edge of acceptance, with Out_Valid=1 in the next cycle.
REQ-019 Out_Valid SHALL clear on Out_Ready without a new transfer; it stays 1 on simultaneous drain and accept (back-to-back, full throughput).
REQ-020 While Out_Valid && !Out_Ready, CMP_OUT and CMP_DATA SHALL hold stable, and no input is accepted.
REQ-021 Compare SHALL use the Signed_Mode value sampled at acceptance; Signed_Mode and CMP_FUN apply per transaction.
REQ-022 MIN/MAX on equal operands SHALL return A.
REQ-023 Tracker: each transfer SHALL update the tracker with A, using that transaction's Signed_Mode ordering.
  - Track_CNT==0: Track_MIN = Track_MAX = A.
  - Otherwise: Track_MIN/Track_MAX are replaced only if A is strictly less/greater.
REQ-024 Track_CNT SHALL increment per transfer and saturate at 2^CNT_WIDTH-1 (no wrap); the extremes keep updating after saturation.
REQ-025 Track_Clear without transfer SHALL set Track_CNT=0, Track_MIN=0, Track_MAX=0.
REQ-026 Track_Clear with a simultaneous transfer SHALL clear first, then treat A as the first sample: Track_CNT=1, Track_MIN=Track_MAX=A.
REQ-027 Track_Clear SHALL NOT affect Out_Valid, CMP_OUT or CMP_DATA.
REQ-028 Tracker outputs SHALL be registered and SHALL reflect a transfer in the cycle after acceptance.

Reset
REQ-029 On RST=1 at a rising edge, all of the following SHALL be 0: Out_Valid, CMP_OUT, CMP_DATA, Track_MIN, Track_MAX, Track_CNT.
REQ-030 RST SHALL override any simultaneous transfer or Track_Clear; a pending unconsumed result is discarded.
REQ-031 In_Ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Signed compare, DATA_WIDTH=16: A=0xFFFD, B=0x0002, CMP_FUN=GT.
  - Signed_Mode=1 -> CMP_OUT=0.
  - Same operands, Signed_Mode=0 -> CMP_OUT=1.
REQ-033 MIN/MAX: A=0x8000, B=0x7FFF, Signed_Mode=1.
  - MIN -> CMP_DATA=0x8000, CMP_OUT=0.
  - MAX -> CMP_DATA=0x7FFF.
  - Equal operands 0x0005 with MIN -> CMP_DATA=0x0005.
REQ-034 Backpressure: Out_Ready=0; send EQ with A=B=7, then NE with A=1, B=2.
  - First result CMP_OUT=1 held; In_Ready=0; second is not accepted.
  - Raise Out_Ready -> first drains; second accepted that cycle; next cycle CMP_OUT=1, Out_Valid=1.
REQ-035 Tracker, signed: accept A=5, -7, 12 -> Track_MIN=0xFFF9, Track_MAX=0x000C, Track_CNT=3.
  - Then Track_Clear with simultaneous A=4 -> Track_CNT=1, Track_MIN=Track_MAX=0x0004.
REQ-036 Saturation, CNT_WIDTH=4: 20 consecutive transfers -> Track_CNT=15 and stays 15.
REQ-037 Reset mid-operation: Out_Valid=1 held with Out_Ready=0, Track_CNT=3; assert RST for one edge.
  - All outputs -> 0; In_Ready=1 after release.

Source files
------------

// File: rtl/cmp_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pipe_unit
// Purpose  : Single-stage pipelined comparator with valid/ready handshake and
//            a running min/max/count tracker over accepted A operands.
//
//            Function codes (CMP_FUN):
//              000 EQ   001 NE   010 GT   011 LT
//              100 GE   101 LE   110 MIN  111 MAX
//            Boolean functions drive CMP_OUT (CMP_DATA = 0); MIN/MAX drive
//            CMP_DATA with the selected operand (CMP_OUT = 0). On equal
//            operands MIN/MAX return A.
//
// Ports    : CLK          clock, all state on rising edge
//            RST          synchronous active-high reset
//            In_Valid     operand pair + function presented
//            In_Ready     block accepts input this cycle (combinational)
//            A, B         operands [DATA_WIDTH]
//            Signed_Mode  1 = two's-complement compare, 0 = unsigned
//            CMP_FUN      function select [3]
//            Track_Clear  clear running tracker
//            Out_Valid    a result is held
//            Out_Ready    consumer takes the result
//            CMP_OUT      boolean result
//            CMP_DATA     MIN/MAX data result [DATA_WIDTH]
//            Track_MIN    running minimum of accepted A [DATA_WIDTH]
//            Track_MAX    running maximum of accepted A [DATA_WIDTH]
//            Track_CNT    accepted samples since last clear [CNT_WIDTH]
//
// Revision : 1.0 - initial release
// ============================================================================
module cmp_pipe_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Signed_Mode,
  input  logic [2:0]            CMP_FUN,
  input  logic                  Track_Clear,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic                  CMP_OUT,
  output logic [DATA_WIDTH-1:0] CMP_DATA,
  output logic [DATA_WIDTH-1:0] Track_MIN,
  output logic [DATA_WIDTH-1:0] Track_MAX,
  output logic [CNT_WIDTH-1:0]  Track_CNT
);

  // Function encodings
  localparam logic [2:0] c_fn_eq  = 3'b000;
  localparam logic [2:0] c_fn_ne  = 3'b001;
  localparam logic [2:0] c_fn_gt  = 3'b010;
  localparam logic [2:0] c_fn_lt  = 3'b011;
  localparam logic [2:0] c_fn_ge  = 3'b100;
  localparam logic [2:0] c_fn_le  = 3'b101;
  localparam logic [2:0] c_fn_min = 3'b110;
  localparam logic [2:0] c_fn_max = 3'b111;

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                  r_out_valid;
  logic                  r_cmp_out;
  logic [DATA_WIDTH-1:0] r_cmp_data;
  logic [DATA_WIDTH-1:0] r_trk_min;
  logic [DATA_WIDTH-1:0] r_trk_max;
  logic [CNT_WIDTH-1:0]  r_trk_cnt;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_xfer;

  // The output register may be overwritten whenever it is empty or being
  // drained in this same cycle, which gives full back-to-back throughput.
  assign w_in_ready = !r_out_valid || Out_Ready;
  assign w_xfer     = In_Valid && w_in_ready;

  // --------------------------------------------------------------------------
  // Operand compare (A vs B)
  // --------------------------------------------------------------------------
  logic w_ab_eq;
  logic w_ab_lt;
  logic w_ab_gt;

  assign w_ab_eq = (A == B);
  assign w_ab_lt = Signed_Mode ? ($signed(A) < $signed(B)) : (A < B);
  assign w_ab_gt = !w_ab_lt && !w_ab_eq;

  logic                  w_res_bit;
  logic [DATA_WIDTH-1:0] w_res_data;

  always_comb begin
    w_res_bit  = 1'b0;
    w_res_data = '0;
    case (CMP_FUN)
      c_fn_eq:  w_res_bit = w_ab_eq;
      c_fn_ne:  w_res_bit = !w_ab_eq;
      c_fn_gt:  w_res_bit = w_ab_gt;
      c_fn_lt:  w_res_bit = w_ab_lt;
      c_fn_ge:  w_res_bit = !w_ab_lt;
      c_fn_le:  w_res_bit = !w_ab_gt;
      // Ties select A for both MIN and MAX.
      c_fn_min: w_res_data = w_ab_gt ? B : A;
      c_fn_max: w_res_data = w_ab_lt ? B : A;
      default: begin
        w_res_bit  = 1'b0;
        w_res_data = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Tracker compare (A vs current extremes), ordered by this transaction's
  // Signed_Mode.
  // --------------------------------------------------------------------------
  logic w_a_lt_min;
  logic w_a_gt_max;
  logic w_trk_first;

  assign w_a_lt_min = Signed_Mode ? ($signed(A) < $signed(r_trk_min)) : (A < r_trk_min);
  assign w_a_gt_max = Signed_Mode ? ($signed(A) > $signed(r_trk_max)) : (A > r_trk_max);

  // A clear coincident with a transfer makes A the first sample.
  assign w_trk_first = Track_Clear || (r_trk_cnt == '0);

  // --------------------------------------------------------------------------
  // Result register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_cmp_out   <= 1'b0;
      r_cmp_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_cmp_out   <= w_res_bit;
      r_cmp_data  <= w_res_data;
    end else if (Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Tracker register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_trk_min <= '0;
      r_trk_max <= '0;
      r_trk_cnt <= '0;
    end else if (w_xfer) begin
      if (w_trk_first) begin
        r_trk_min <= A;
        r_trk_max <= A;
        r_trk_cnt <= c_cnt_one;
      end else begin
        if (w_a_lt_min) begin
          r_trk_min <= A;
        end
        if (w_a_gt_max) begin
          r_trk_max <= A;
        end
        // Saturate rather than wrap; extremes keep updating regardless.
        if (r_trk_cnt != c_cnt_max) begin
          r_trk_cnt <= r_trk_cnt + c_cnt_one;
        end
      end
    end else if (Track_Clear) begin
      r_trk_min <= '0;
      r_trk_max <= '0;
      r_trk_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign In_Ready  = w_in_ready;
  assign Out_Valid = r_out_valid;
  assign CMP_OUT   = r_cmp_out;
  assign CMP_DATA  = r_cmp_data;
  assign Track_MIN = r_trk_min;
  assign Track_MAX = r_trk_max;
  assign Track_CNT = r_trk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmp_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_pipe_unit
// Purpose  : Directed self-checking bench for cmp_pipe_unit
//            (DATA_WIDTH=16, CNT_WIDTH=4 so counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_pipe_unit;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          In_Valid;
  logic          In_Ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          Signed_Mode;
  logic [2:0]    CMP_FUN;
  logic          Track_Clear;
  logic          Out_Valid;
  logic          Out_Ready;
  logic          CMP_OUT;
  logic [DW-1:0] CMP_DATA;
  logic [DW-1:0] Track_MIN;
  logic [DW-1:0] Track_MAX;
  logic [CW-1:0] Track_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  cmp_pipe_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .A           (A),
    .B           (B),
    .Signed_Mode (Signed_Mode),
    .CMP_FUN     (CMP_FUN),
    .Track_Clear (Track_Clear),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .CMP_OUT     (CMP_OUT),
    .CMP_DATA    (CMP_DATA),
    .Track_MIN   (Track_MIN),
    .Track_MAX   (Track_MAX),
    .Track_CNT   (Track_CNT)
  );

  // One accepted transfer: present, clock, withdraw; outputs then settled.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [2:0] fn, input logic sm);
    A = a; B = b; CMP_FUN = fn; Signed_Mode = sm; In_Valid = 1'b1;
    @(posedge CLK); #1;
    In_Valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; In_Valid = 1'b0; Track_Clear = 1'b0; Out_Ready = 1'b0;
    A = '0; B = '0; CMP_FUN = 3'd0; Signed_Mode = 1'b0;
    tick(); tick();
    RST = 1'b0; #1;
    n_checks++;
    if ({Out_Valid, CMP_OUT, CMP_DATA, Track_MIN, Track_MAX, Track_CNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ov=%0b out=%0b data=%h min=%h max=%h cnt=%0d, expected all 0",
               Out_Valid, CMP_OUT, CMP_DATA, Track_MIN, Track_MAX, Track_CNT);
    end
    n_checks++;
    if (In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", In_Ready);
    end
  endtask

  task automatic test_signed_cmp();
    Out_Ready = 1'b1;
    send(16'hFFFD, 16'h0002, 3'b010, 1'b1);
    n_checks++;
    if (Out_Valid !== 1'b1 || CMP_OUT !== 1'b0 || CMP_DATA !== 16'h0) begin
      n_fail++;
      $display("FAIL gt_signed: ov=%b out=%b data=%h expected ov=1 out=0 data=0000", Out_Valid, CMP_OUT, CMP_DATA);
    end
    send(16'hFFFD, 16'h0002, 3'b010, 1'b0);
    n_checks++;
    if (Out_Valid !== 1'b1 || CMP_OUT !== 1'b1) begin
      n_fail++; $display("FAIL gt_unsigned: ov=%b out=%b expected ov=1 out=1", Out_Valid, CMP_OUT);
    end
  endtask

  // A=3, B=5 unsigned across all eight functions.
  task automatic test_func_table();
    logic [7:0]    exp_bits;
    logic [DW-1:0] exp_data [8];
    exp_bits = 8'b0010_1010;  // bit f: EQ0 NE1 GT0 LT1 GE0 LE1 MIN0 MAX0
    for (int f = 0; f < 8; f++) exp_data[f] = '0;
    exp_data[6] = 16'd3;
    exp_data[7] = 16'd5;
    for (int f = 0; f < 8; f++) begin
      send(16'd3, 16'd5, f[2:0], 1'b0);
      n_checks++;
      if (CMP_OUT !== exp_bits[f] || CMP_DATA !== exp_data[f]) begin
        n_fail++;
        $display("FAIL func_%0d: out=%b data=%h expected out=%b data=%h",
                 f, CMP_OUT, CMP_DATA, exp_bits[f], exp_data[f]);
      end
    end
  endtask

  task automatic test_minmax();
    Out_Ready = 1'b1;
    send(16'h8000, 16'h7FFF, 3'b110, 1'b1);
    n_checks++;
    if (CMP_DATA !== 16'h8000 || CMP_OUT !== 1'b0) begin
      n_fail++; $display("FAIL min_signed: data=%h out=%b expected 8000 0", CMP_DATA, CMP_OUT);
    end
    send(16'h8000, 16'h7FFF, 3'b111, 1'b1);
    n_checks++;
    if (CMP_DATA !== 16'h7FFF) begin
      n_fail++; $display("FAIL max_signed: data=%h expected 7fff", CMP_DATA);
    end
    send(16'h0005, 16'h0005, 3'b110, 1'b1);
    n_checks++;
    if (CMP_DATA !== 16'h0005) begin
      n_fail++; $display("FAIL min_equal: data=%h expected 0005", CMP_DATA);
    end
  endtask

  task automatic test_tracker();
    // Clear alone while a result is held: tracker zeroes, result untouched.
    Out_Ready = 1'b0; Track_Clear = 1'b1;
    tick();
    Track_Clear = 1'b0;
    n_checks++;
    if (Out_Valid !== 1'b1 || CMP_DATA !== 16'h0005 || CMP_OUT !== 1'b0) begin
      n_fail++; $display("FAIL clear_keeps_result: ov=%b data=%h out=%b expected 1 0005 0", Out_Valid, CMP_DATA, CMP_OUT);
    end
    n_checks++;
    if (Track_CNT !== 4'd0 || Track_MIN !== 16'h0 || Track_MAX !== 16'h0) begin
      n_fail++; $display("FAIL clear_only: cnt=%0d min=%h max=%h expected 0 0000 0000", Track_CNT, Track_MIN, Track_MAX);
    end
    Out_Ready = 1'b1;
    send(16'd5,    16'd0, 3'b000, 1'b1);
    send(16'hFFF9, 16'd0, 3'b000, 1'b1);
    send(16'd12,   16'd0, 3'b000, 1'b1);
    n_checks++;
    if (Track_MIN !== 16'hFFF9 || Track_MAX !== 16'h000C || Track_CNT !== 4'd3) begin
      n_fail++; $display("FAIL track_signed: min=%h max=%h cnt=%0d expected fff9 000c 3", Track_MIN, Track_MAX, Track_CNT);
    end
    Track_Clear = 1'b1;
    send(16'd4, 16'd0, 3'b000, 1'b1);
    Track_Clear = 1'b0;
    n_checks++;
    if (Track_MIN !== 16'h0004 || Track_MAX !== 16'h0004 || Track_CNT !== 4'd1) begin
      n_fail++; $display("FAIL clear_with_xfer: min=%h max=%h cnt=%0d expected 0004 0004 1", Track_MIN, Track_MAX, Track_CNT);
    end
  endtask

  task automatic test_backpressure();
    Out_Ready = 1'b1; tick();           // drain anything held
    Track_Clear = 1'b1; tick(); Track_Clear = 1'b0;
    Out_Ready = 1'b0;
    send(16'd7, 16'd7, 3'b000, 1'b0);
    A = 16'd1; B = 16'd2; CMP_FUN = 3'b001; In_Valid = 1'b1; #1;
    n_checks++;
    if (In_Ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready: got %b expected 0", In_Ready);
    end
    tick();
    n_checks++;
    if (Out_Valid !== 1'b1 || CMP_OUT !== 1'b1 || Track_CNT !== 4'd1) begin
      n_fail++; $display("FAIL bp_hold: ov=%b out=%b cnt=%0d expected 1 1 1", Out_Valid, CMP_OUT, Track_CNT);
    end
    Out_Ready = 1'b1; #1;
    n_checks++;
    if (In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 1", In_Ready);
    end
    tick();
    In_Valid = 1'b0;
    n_checks++;
    if (Out_Valid !== 1'b1 || CMP_OUT !== 1'b1 || Track_CNT !== 4'd2) begin
      n_fail++; $display("FAIL bp_second: ov=%b out=%b cnt=%0d expected 1 1 2", Out_Valid, CMP_OUT, Track_CNT);
    end
    tick();
    n_checks++;
    if (Out_Valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: ov=%b expected 0", Out_Valid);
    end
  endtask

  // Back-to-back transfers at full rate, driving the counter into saturation.
  task automatic test_back_to_back();
    Out_Ready = 1'b1; Track_Clear = 1'b1; tick(); Track_Clear = 1'b0;
    Signed_Mode = 1'b0; CMP_FUN = 3'b000; B = '0; In_Valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      A = 16'(i);
      tick();
    end
    n_checks++;
    if (Track_CNT !== 4'd15 || Track_MIN !== 16'd0 || Track_MAX !== 16'd19 || Out_Valid !== 1'b1) begin
      n_fail++; $display("FAIL saturate: cnt=%0d min=%h max=%h ov=%b expected 15 0000 0013 1", Track_CNT, Track_MIN, Track_MAX, Out_Valid);
    end
    A = 16'd40; tick();
    In_Valid = 1'b0;
    n_checks++;
    if (Track_CNT !== 4'd15 || Track_MAX !== 16'd40) begin
      n_fail++; $display("FAIL saturate_hold: cnt=%0d max=%h expected 15 0028", Track_CNT, Track_MAX);
    end
  endtask

  task automatic test_reset_mid();
    Out_Ready = 1'b1; Track_Clear = 1'b1;
    send(16'd1, 16'd1, 3'b000, 1'b0);
    Track_Clear = 1'b0;
    send(16'd2, 16'd2, 3'b000, 1'b0);
    send(16'd3, 16'd3, 3'b111, 1'b0);
    Out_Ready = 1'b0;
    tick();
    n_checks++;
    if (Out_Valid !== 1'b1 || Track_CNT !== 4'd3 || CMP_DATA !== 16'd3) begin
      n_fail++; $display("FAIL pre_reset: ov=%b cnt=%0d data=%h expected 1 3 0003", Out_Valid, Track_CNT, CMP_DATA);
    end
    // Reset with a competing transfer request and clear.
    RST = 1'b1; In_Valid = 1'b1; Track_Clear = 1'b1; Out_Ready = 1'b1; A = 16'd9;
    tick();
    RST = 1'b0; In_Valid = 1'b0; Track_Clear = 1'b0; Out_Ready = 1'b0; #1;
    n_checks++;
    if ({Out_Valid, CMP_OUT, CMP_DATA, Track_MIN, Track_MAX, Track_CNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%0b out=%0b data=%h min=%h max=%h cnt=%0d expected all 0",
               Out_Valid, CMP_OUT, CMP_DATA, Track_MIN, Track_MAX, Track_CNT);
    end
    n_checks++;
    if (In_Ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_ready: got %b expected 1", In_Ready);
    end
  endtask

  initial begin
    test_reset();
    test_signed_cmp();
    test_func_table();
    test_minmax();
    test_tracker();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
